// File: rtl/alu_mul_seq.sv
// alu_mul_seq
//   Iterative unsigned 32x32 shift-add multiplier. It has no adder of its own:
//   it borrows the EXE-stage ALU between the operand mux and the ALU. The
//   pipeline has priority, and a starvation guard forces one sequencer cycle
//   after STARVE_LIM consecutive stalled iterations.
//   Optional early termination is compiled in when MUL_SKIP_EN is defined.

module alu_mul_seq #(
   parameter int ALU_OP_W   = 19,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         mul_src1,
   input  logic [31:0]         mul_src2,
   input  logic                op_hi,
   output logic                busy,
   output logic                done,
   output logic [31:0]         result,
   input  logic                pipe_req,
   input  logic [ALU_OP_W-1:0] pipe_alu_op,
   input  logic [31:0]         pipe_src1,
   input  logic [31:0]         pipe_src2,
   output logic                pipe_grant,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [31:0]         alu_src1,
   output logic [31:0]         alu_src2,
   input  logic [31:0]         alu_result
);

   localparam int                  SW         = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [ALU_OP_W-1:0] OP_ADD     = ALU_OP_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic [31:0]   r_result;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_mcand;
   logic          r_op_hi;
   logic [5:0]    r_count;
   logic [SW-1:0] r_starve;
`ifdef MUL_SKIP_EN
   logic [31:0]   r_mrem;
   logic [5:0]    w_shamt;
   logic [63:0]   w_skip_prod;
`endif

   logic          w_run;
   logic          w_need;
   logic          w_skip;
   logic          w_seq_own;
   logic          w_advance;
   logic          w_carry;
   logic          w_fin;
   logic [63:0]   w_prod_next;
   logic [63:0]   w_fin_prod;

   // Iteration datapath: ownership decision, next {hi,lo}, and completion.
   // NOTE: every signal driven here gets a value on every path, so no latches.
   always_comb begin
      w_run  = (r_state == S_RUN);
      w_need = r_lo[0];
`ifdef MUL_SKIP_EN
      // Remaining multiplier bits all zero: finish with one wide shift.
      w_skip = w_run && (r_mrem == 32'd0);
`else
      w_skip = 1'b0;
`endif
      w_seq_own = w_run && !w_skip && w_need &&
                  (!pipe_req || (r_starve == STARVE_MAX));
      w_advance = w_run && !w_skip && (!w_need || w_seq_own);
      // Carry-out of hi + mcand recovered from the ALU's 32-bit sum.
      w_carry   = (r_hi[31] & r_mcand[31]) |
                  ((r_hi[31] ^ r_mcand[31]) & ~alu_result[31]);
      w_prod_next = w_need ? {w_carry, alu_result, r_lo[31:1]}
                           : {1'b0,    r_hi,       r_lo[31:1]};
      w_fin      = w_advance && (r_count == 6'd31);
      w_fin_prod = w_prod_next;
`ifdef MUL_SKIP_EN
      w_shamt     = 6'd32 - r_count;
      w_skip_prod = {r_hi, r_lo} >> w_shamt;
      if (w_skip) begin
         w_fin      = 1'b1;
         w_fin_prod = w_skip_prod;
      end
`endif
   end

   // ALU operand mux: the pipeline drives the ALU unless the sequencer owns it.
   always_comb begin
      pipe_grant = !w_seq_own;
      if (w_seq_own) begin
         alu_op   = OP_ADD;
         alu_src1 = r_hi;
         alu_src2 = r_mcand;
      end else begin
         alu_op   = pipe_alu_op;
         alu_src1 = pipe_src1;
         alu_src2 = pipe_src2;
      end
   end

   // Sequencer FSM with registered busy/done/result and starvation counter.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 32'd0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_mcand  <= 32'd0;
         r_op_hi  <= 1'b0;
         r_count  <= 6'd0;
         r_starve <= '0;
`ifdef MUL_SKIP_EN
         r_mrem   <= 32'd0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_mcand <= mul_src1;
                  r_lo    <= mul_src2;
                  r_hi    <= 32'd0;
                  r_count <= 6'd0;
                  r_op_hi <= op_hi;
`ifdef MUL_SKIP_EN
                  r_mrem  <= mul_src2;
`endif
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (w_run && w_need && !w_skip) begin
                  r_starve <= w_seq_own ? '0 : r_starve + 1'b1;
               end
               if (w_advance) begin
                  r_hi    <= w_prod_next[63:32];
                  r_lo    <= w_prod_next[31:0];
                  r_count <= r_count + 6'd1;
`ifdef MUL_SKIP_EN
                  r_mrem  <= r_mrem >> 1;
`endif
               end
               if (w_fin) begin
                  r_result <= r_op_hi ? w_fin_prod[63:32] : w_fin_prod[31:0];
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: table-driven vectors with a result scoreboard, plus hand
// sequences for passthrough, ALU contention and reset during a multiply.

module tb_alu_mul_seq;

   localparam int ALU_OP_W = 19;
   localparam int LIMIT    = 200;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [31:0]         mul_src1;
   logic [31:0]         mul_src2;
   logic                op_hi;
   logic                busy;
   logic                done;
   logic [31:0]         result;
   logic                pipe_req;
   logic [ALU_OP_W-1:0] pipe_alu_op;
   logic [31:0]         pipe_src1;
   logic [31:0]         pipe_src2;
   logic                pipe_grant;
   logic [ALU_OP_W-1:0] alu_op;
   logic [31:0]         alu_src1;
   logic [31:0]         alu_src2;
   logic [31:0]         alu_result;

   int n_vec = 0;
   int n_bad = 0;

   logic [31:0] sb_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        hi;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   alu_mul_seq #(.ALU_OP_W(ALU_OP_W), .STARVE_LIM(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .mul_src1(mul_src1), .mul_src2(mul_src2), .op_hi(op_hi),
      .busy(busy), .done(done), .result(result),
      .pipe_req(pipe_req), .pipe_alu_op(pipe_alu_op),
      .pipe_src1(pipe_src1), .pipe_src2(pipe_src2), .pipe_grant(pipe_grant),
      .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   // Stand-in ALU: bit 0 is add, any other control word gives XOR.
   assign alu_result = alu_op[0] ? (alu_src1 + alu_src2) : (alu_src1 ^ alu_src2);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Cycles spent in RUN for a multiplier value, with no stalls.
   function automatic int exp_run(input logic [31:0] b);
`ifdef MUL_SKIP_EN
      int msb;
      if (b == 32'd0) return 1;
      msb = 0;
      for (int i = 0; i < 32; i++) if (b[i]) msb = i;
      return (msb == 31) ? 32 : msb + 2;
`else
      return 32;
`endif
   endfunction

   // Scoreboard: each done pulse retires the oldest expected result.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1, expected no pending multiply");
         end else begin
            check("result", {32'd0, result}, {32'd0, sb_q.pop_front()});
         end
      end
   end

   // Waits (from cycle n0 after the start edge) for done; counts busy cycles.
   // poke re-asserts start with junk operands in cycle 5, which must be ignored.
   task automatic wait_done(input int n0, input bit poke, output int n, output int nb);
      n  = n0;
      nb = 0;
      while (n < LIMIT) begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (poke && n == 5) begin
            start    = 1'b1;
            mul_src1 = 32'd99;
            mul_src2 = 32'd99;
         end
         if (poke && n == 6) start = 1'b0;
         if (done) break;
         if (busy) nb++;
      end
   endtask

   // Drives one multiply from the current negedge and checks its timing.
   task automatic run_mul(input vec_t v, input bit poke);
      int n, nb;
      mul_src1 = v.a;
      mul_src2 = v.b;
      op_hi    = v.hi;
      start    = 1'b1;
      sb_q.push_back(v.exp);
      @(posedge clk);
      wait_done(0, poke, n, nb);
      check("done_cycle", 64'(n), 64'(exp_run(v.b) + 1));
      check("busy_cycles", 64'(nb), 64'(exp_run(v.b)));
      check("busy_at_done", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, nb, cnt;
      vec_t v;

      tbl.push_back('{32'd3,          32'd5,          1'b0, 32'h0000000F});
      tbl.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 32'hFFFFFFFE});
      tbl.push_back('{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'h00000001});
      tbl.push_back('{32'd7,          32'd2,          1'b0, 32'd14});
      tbl.push_back('{32'd5,          32'd0,          1'b0, 32'd0});
      tbl.push_back('{32'hDEADBEEF,   32'h10,         1'b0, 32'hEADBEEF0});
      tbl.push_back('{32'hDEADBEEF,   32'h10,         1'b1, 32'h0000000D});
      tbl.push_back('{32'h80000000,   32'h80000000,   1'b1, 32'h40000000});
      tbl.push_back('{32'd1,          32'hFFFFFFFF,   1'b0, 32'hFFFFFFFF});
      tbl.push_back('{32'h00010000,   32'h00010000,   1'b1, 32'h00000001});
      tbl.push_back('{32'hFFFFFFFF,   32'd2,          1'b1, 32'h00000001});
      for (int i = 0; i < 3; i++) begin
         logic [63:0] p;
         v.a  = $urandom;
         v.b  = $urandom;
         v.hi = i[0];
         p    = {32'd0, v.a} * {32'd0, v.b};
         v.exp = v.hi ? p[63:32] : p[31:0];
         tbl.push_back(v);
      end

      reset       = 1'b1;
      start       = 1'b0;
      mul_src1    = 32'd0;
      mul_src2    = 32'd0;
      op_hi       = 1'b0;
      pipe_req    = 1'b0;
      pipe_alu_op = '0;
      pipe_src1   = 32'd0;
      pipe_src2   = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy",   {63'd0, busy},   64'd0);
      check("reset_done",   {63'd0, done},   64'd0);
      check("reset_result", {32'd0, result}, 64'd0);
      reset = 1'b0;

      // Passthrough in IDLE.
      pipe_req    = 1'b1;
      pipe_alu_op = 19'h10;
      pipe_src1   = 32'hF0;
      pipe_src2   = 32'h3C;
      @(negedge clk);
      check("pass_alu_op",   64'(alu_op),        64'h10);
      check("pass_src1",     {32'd0, alu_src1},  64'hF0);
      check("pass_src2",     {32'd0, alu_src2},  64'h3C);
      check("pass_grant",    {63'd0, pipe_grant}, 64'd1);
      check("pass_busy",     {63'd0, busy},      64'd0);
      pipe_req = 1'b0;

      // Table vectors back to back; each start after the first lands in DONE.
      for (int i = 0; i < tbl.size(); i++) run_mul(tbl[i], i == 0);

      // Contention: pipeline holds the ALU, guard forces the 5th cycle.
      @(negedge clk);
      pipe_req    = 1'b1;
      pipe_alu_op = 19'h10;
      mul_src1    = 32'd7;
      mul_src2    = 32'd1;
      op_hi       = 1'b0;
      start       = 1'b1;
      sb_q.push_back(32'd7);
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k <= 4) begin
            check("stall_grant", {63'd0, pipe_grant}, 64'd1);
            check("stall_alu_op", 64'(alu_op), 64'h10);
         end else begin
            check("force_grant", {63'd0, pipe_grant}, 64'd0);
            check("force_alu_op", 64'(alu_op), 64'h1);
            check("force_src1", {32'd0, alu_src1}, 64'd0);
            check("force_src2", {32'd0, alu_src2}, 64'd7);
         end
      end
      wait_done(5, 1'b0, n, nb);
      check("contend_done_cycle", 64'(n), 64'(exp_run(32'd1) + 4 + 1));
      pipe_req = 1'b0;

      // Reset in the middle of a multiply: no done, result cleared.
      @(negedge clk);
      mul_src1 = 32'h12345;
      mul_src2 = 32'h6789;
      op_hi    = 1'b0;
      start    = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
`ifndef MUL_SKIP_EN
      check("busy_before_reset", {63'd0, busy}, 64'd1);
`endif
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy",   {63'd0, busy},   64'd0);
      check("abort_done",   {63'd0, done},   64'd0);
      check("abort_result", {32'd0, result}, 64'd0);
      reset = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check("no_done_after_abort", 64'(cnt), 64'd0);
      v = '{32'd6, 32'd7, 1'b0, 32'd42};
      run_mul(v, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
